// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: default payload widths,
// the bubble (NOP) encoding and the occupancy states of a skid-buffered stage.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

    // EMPTY: nothing held; ONE: main entry only; FULL: main and skid entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd3
    } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional skid entry (registered in_ready) and a saturating bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_W = INSTR_W + PC_W,
    parameter logic [DATA_W-1:0]    BUBBLE = DATA_W'(NOP_BUBBLE),
    parameter bit                   SKID   = 1'b1,
    parameter int unsigned          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  bubble_cnt
);

    if (SKID) begin : g_skid

        stage_state_e      state_q, state_d;
        logic [DATA_W-1:0] main_data_q, main_data_d;
        logic [DATA_W-1:0] skid_data_q, skid_data_d;
        logic              in_ready_q, in_ready_d;
        logic              accept;
        logic              drain;

        assign accept = in_valid & in_ready_q;
        assign drain  = (state_q != ST_EMPTY) & out_ready;

        always_comb begin
            state_d     = state_q;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;

            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                    end else if (accept && drain) begin
                        main_data_d = in_data;
                    end else if (drain) begin
                        state_d     = ST_EMPTY;
                        main_data_d = BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        skid_data_d = BUBBLE;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_data_d = BUBBLE;
                    skid_data_d = BUBBLE;
                end
            endcase

            // A drain in the flush cycle has already been sampled downstream,
            // so flush only has to discard whatever would remain afterwards.
            if (flush) begin
                state_d     = ST_EMPTY;
                main_data_d = BUBBLE;
                skid_data_d = BUBBLE;
            end

            in_ready_d = (state_d != ST_FULL);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q     <= ST_EMPTY;
                main_data_q <= BUBBLE;
                skid_data_q <= BUBBLE;
                in_ready_q  <= 1'b1;
            end else begin
                state_q     <= state_d;
                main_data_q <= main_data_d;
                skid_data_q <= skid_data_d;
                in_ready_q  <= in_ready_d;
            end
        end

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != ST_EMPTY);
        assign out_data  = main_data_q;

    end else begin : g_single

        logic              valid_q, valid_d;
        logic [DATA_W-1:0] data_q, data_d;
        logic              ready_c;
        logic              accept;
        logic              drain;

        assign ready_c = ~valid_q | out_ready;
        assign accept  = in_valid & ready_c;
        assign drain   = valid_q & out_ready;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (flush) begin
                valid_d = 1'b0;
                data_d  = BUBBLE;
            end else if (accept) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (drain) begin
                valid_d = 1'b0;
                data_d  = BUBBLE;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= BUBBLE;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign in_ready  = ready_c;
        assign out_valid = valid_q;
        assign out_data  = data_q;

    end

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_ready & ~out_valid),
        .cnt   (bubble_cnt)
    );

endmodule
